// File: rtl/mem_thread_glue.sv
// rtl/mem_thread_glue.sv - EX->MEM->WB glue carrying one thread-tagged op at a time
//
// Purpose: accepts one op from EX, issues a d-cache request for loads/stores
// (address optionally tagged with the thread ID in its MSBs), waits for load
// data and presents a single write-back beat. ALU ops go straight to WB.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_valid / o_ready         EX op handshake (o_ready only in IDLE)
//   i_thread_id ... i_rw_addr EX op fields
//   o_dc_* / i_dc_ready       d-cache request channel
//   i_dc_rsp_valid/_data      d-cache load response
//   o_wb_* / i_wb_ready       write-back beat channel
//   o_thread_busy             one-hot owner of the in-flight op
//   o_bad_tid                 pulse: op dropped for out-of-range thread ID
//   o_spurious_rsp            pulse: response arrived outside WAIT
module mem_thread_glue #(
  parameter int NUM_THREADS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_TAG_EN    = 1,
  localparam int TID_W         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [TID_W-1:0]          i_thread_id,
  input  logic                      i_is_mem_access,
  input  logic                      i_mem_action,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_sw_data,
  input  logic                      i_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0] i_rw_addr,
  output logic                      o_dc_valid,
  input  logic                      i_dc_ready,
  output logic                      o_dc_mem_action,
  output logic [ADDR_WIDTH-1:0]     o_dc_addr,
  output logic [DATA_WIDTH-1:0]     o_dc_data,
  input  logic                      i_dc_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     i_dc_rsp_data,
  output logic                      o_wb_valid,
  input  logic                      i_wb_ready,
  output logic [TID_W-1:0]          o_wb_thread_id,
  output logic                      o_wb_uses_rw,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_rw_addr,
  output logic [DATA_WIDTH-1:0]     o_wb_rw_data,
  output logic [NUM_THREADS-1:0]    o_thread_busy,
  output logic                      o_bad_tid,
  output logic                      o_spurious_rsp
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

  state_e                    state_q, state_d;
  logic [TID_W-1:0]          tid_q, tid_d;
  logic                      action_q, action_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     sw_q, sw_d;
  logic                      uses_rw_q, uses_rw_d;
  logic [REG_ADDR_WIDTH-1:0] rw_addr_q, rw_addr_d;
  logic [DATA_WIDTH-1:0]     rw_data_q, rw_data_d;
  logic                      bad_tid_q, bad_tid_d;
  logic                      spur_q, spur_d;

  logic [ADDR_WIDTH-1:0]     tagged_addr;
  logic                      tid_ok;

  // Thread tag replaces the top TID_W address bits; without tagging (or a
  // single thread) the low ALU bits pass straight through.
  generate
    if (ADDR_TAG_EN != 0 && NUM_THREADS > 1) begin : g_tag
      assign tagged_addr = {i_thread_id, i_alu_result[ADDR_WIDTH-TID_W-1:0]};
    end else begin : g_notag
      assign tagged_addr = i_alu_result[ADDR_WIDTH-1:0];
    end
  endgenerate

  // Extra bit so the compare also works when NUM_THREADS is a power of two.
  assign tid_ok = ({1'b0, i_thread_id} < (TID_W+1)'(NUM_THREADS));

  always_comb begin
    state_d   = state_q;
    tid_d     = tid_q;
    action_d  = action_q;
    addr_d    = addr_q;
    sw_d      = sw_q;
    uses_rw_d = uses_rw_q;
    rw_addr_d = rw_addr_q;
    rw_data_d = rw_data_q;
    bad_tid_d = 1'b0;
    spur_d    = i_dc_rsp_valid && (state_q != S_WAIT);
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (!tid_ok) begin
            bad_tid_d = 1'b1;
          end else begin
            tid_d     = i_thread_id;
            uses_rw_d = i_uses_rw;
            rw_addr_d = i_rw_addr;
            if (i_is_mem_access) begin
              action_d = i_mem_action;
              addr_d   = tagged_addr;
              sw_d     = i_sw_data;
              state_d  = S_REQ;
            end else begin
              rw_data_d = i_alu_result;
              state_d   = S_WB;
            end
          end
        end
      end
      S_REQ: begin
        // Stores complete on acceptance; loads wait for data.
        if (i_dc_ready) begin
          state_d = action_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_dc_rsp_valid) begin
          rw_data_d = i_dc_rsp_data;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        if (i_wb_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tid_q     <= '0;
      action_q  <= 1'b0;
      addr_q    <= '0;
      sw_q      <= '0;
      uses_rw_q <= 1'b0;
      rw_addr_q <= '0;
      rw_data_q <= '0;
      bad_tid_q <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tid_q     <= tid_d;
      action_q  <= action_d;
      addr_q    <= addr_d;
      sw_q      <= sw_d;
      uses_rw_q <= uses_rw_d;
      rw_addr_q <= rw_addr_d;
      rw_data_q <= rw_data_d;
      bad_tid_q <= bad_tid_d;
      spur_q    <= spur_d;
    end
  end

  always_comb begin
    o_thread_busy = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      o_thread_busy[t] = (state_q != S_IDLE) && (tid_q == TID_W'(t));
    end
  end

  assign o_ready         = (state_q == S_IDLE);
  assign o_dc_valid      = (state_q == S_REQ);
  assign o_dc_mem_action = action_q;
  assign o_dc_addr       = addr_q;
  assign o_dc_data       = sw_q;
  assign o_wb_valid      = (state_q == S_WB);
  assign o_wb_thread_id  = tid_q;
  assign o_wb_uses_rw    = uses_rw_q;
  assign o_wb_rw_addr    = rw_addr_q;
  assign o_wb_rw_data    = rw_data_q;
  assign o_bad_tid       = bad_tid_q;
  assign o_spurious_rsp  = spur_q;

endmodule

// File: tb/tb_mem_thread_glue.sv
// tb/tb_mem_thread_glue.sv - scoreboard bench for mem_thread_glue
module tb_mem_thread_glue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared op fields and handshake inputs
  logic        is_mem, action, uses_rw, dc_ready, rsp_valid, wb_ready;
  logic [31:0] alu, sw, rsp_data;
  logic [4:0]  rw_addr;

  // DUT A: 2 threads, tagged
  logic        a_valid, a_tid, a_ready, a_dc_valid, a_dc_action, a_wb_valid, a_wb_tid;
  logic        a_wb_uses, a_bad, a_spur;
  logic [15:0] a_dc_addr;
  logic [31:0] a_dc_data, a_wb_data;
  logic [4:0]  a_wb_ra;
  logic [1:0]  a_busy;
  // DUT B: 3 threads, tagged
  logic        b_valid, b_ready, b_dc_valid, b_dc_action, b_wb_valid, b_wb_uses, b_bad, b_spur;
  logic [1:0]  b_tid, b_wb_tid;
  logic [15:0] b_dc_addr;
  logic [31:0] b_dc_data, b_wb_data;
  logic [4:0]  b_wb_ra;
  logic [2:0]  b_busy;
  // DUT C: 2 threads, untagged
  logic        c_valid, c_tid, c_ready, c_dc_valid, c_dc_action, c_wb_valid, c_wb_tid;
  logic        c_wb_uses, c_bad, c_spur;
  logic [15:0] c_dc_addr;
  logic [31:0] c_dc_data, c_wb_data;
  logic [4:0]  c_wb_ra;
  logic [1:0]  c_busy;

  mem_thread_glue #(.NUM_THREADS(2), .ADDR_TAG_EN(1)) u_a (
    .clk(clk), .rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_thread_id(a_tid),
    .i_is_mem_access(is_mem), .i_mem_action(action), .i_alu_result(alu), .i_sw_data(sw),
    .i_uses_rw(uses_rw), .i_rw_addr(rw_addr), .o_dc_valid(a_dc_valid), .i_dc_ready(dc_ready),
    .o_dc_mem_action(a_dc_action), .o_dc_addr(a_dc_addr), .o_dc_data(a_dc_data),
    .i_dc_rsp_valid(rsp_valid), .i_dc_rsp_data(rsp_data), .o_wb_valid(a_wb_valid),
    .i_wb_ready(wb_ready), .o_wb_thread_id(a_wb_tid), .o_wb_uses_rw(a_wb_uses),
    .o_wb_rw_addr(a_wb_ra), .o_wb_rw_data(a_wb_data), .o_thread_busy(a_busy),
    .o_bad_tid(a_bad), .o_spurious_rsp(a_spur));

  mem_thread_glue #(.NUM_THREADS(3), .ADDR_TAG_EN(1)) u_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_thread_id(b_tid),
    .i_is_mem_access(is_mem), .i_mem_action(action), .i_alu_result(alu), .i_sw_data(sw),
    .i_uses_rw(uses_rw), .i_rw_addr(rw_addr), .o_dc_valid(b_dc_valid), .i_dc_ready(dc_ready),
    .o_dc_mem_action(b_dc_action), .o_dc_addr(b_dc_addr), .o_dc_data(b_dc_data),
    .i_dc_rsp_valid(rsp_valid), .i_dc_rsp_data(rsp_data), .o_wb_valid(b_wb_valid),
    .i_wb_ready(wb_ready), .o_wb_thread_id(b_wb_tid), .o_wb_uses_rw(b_wb_uses),
    .o_wb_rw_addr(b_wb_ra), .o_wb_rw_data(b_wb_data), .o_thread_busy(b_busy),
    .o_bad_tid(b_bad), .o_spurious_rsp(b_spur));

  mem_thread_glue #(.NUM_THREADS(2), .ADDR_TAG_EN(0)) u_c (
    .clk(clk), .rst(rst), .i_valid(c_valid), .o_ready(c_ready), .i_thread_id(c_tid),
    .i_is_mem_access(is_mem), .i_mem_action(action), .i_alu_result(alu), .i_sw_data(sw),
    .i_uses_rw(uses_rw), .i_rw_addr(rw_addr), .o_dc_valid(c_dc_valid), .i_dc_ready(dc_ready),
    .o_dc_mem_action(c_dc_action), .o_dc_addr(c_dc_addr), .o_dc_data(c_dc_data),
    .i_dc_rsp_valid(rsp_valid), .i_dc_rsp_data(rsp_data), .o_wb_valid(c_wb_valid),
    .i_wb_ready(wb_ready), .o_wb_thread_id(c_wb_tid), .o_wb_uses_rw(c_wb_uses),
    .o_wb_rw_addr(c_wb_ra), .o_wb_rw_data(c_wb_data), .o_thread_busy(c_busy),
    .o_bad_tid(c_bad), .o_spurious_rsp(c_spur));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic act; logic [15:0] addr; logic [31:0] data;} dc_t;
  typedef struct packed {logic tid; logic uses; logic [4:0] ra; logic [31:0] rd;} wb_t;
  dc_t dc_q[$];
  wb_t wb_q[$];

  // Monitor for DUT A: every cycle a channel is valid its fields must match
  // the head expectation; the head is retired on the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_dc_valid) begin
        if (dc_q.size() == 0) begin
          chk("unexpected_dc_req", {31'd0, a_dc_valid}, 32'd0);
        end else begin
          chk("dc_action", {31'd0, a_dc_action}, {31'd0, dc_q[0].act});
          chk("dc_addr", {16'd0, a_dc_addr}, {16'd0, dc_q[0].addr});
          chk("dc_data", a_dc_data, dc_q[0].data);
          if (dc_ready) void'(dc_q.pop_front());
        end
      end
      if (a_wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb_beat", {31'd0, a_wb_valid}, 32'd0);
        end else begin
          chk("wb_tid", {31'd0, a_wb_tid}, {31'd0, wb_q[0].tid});
          chk("wb_uses_rw", {31'd0, a_wb_uses}, {31'd0, wb_q[0].uses});
          chk("wb_rw_addr", {27'd0, a_wb_ra}, {27'd0, wb_q[0].ra});
          chk("wb_rw_data", a_wb_data, wb_q[0].rd);
          if (wb_ready) void'(wb_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic m, input logic act, input logic [31:0] a,
                        input logic [31:0] s, input logic u, input logic [4:0] ra);
    is_mem = m; action = act; alu = a; sw = s; uses_rw = u; rw_addr = ra;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; c_valid = 0; a_tid = 0; b_tid = 0; c_tid = 0;
    dc_ready = 0; rsp_valid = 0; rsp_data = 0; wb_ready = 0;
    set_op(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 1);
    chk("rst_dc_valid", {31'd0, a_dc_valid}, 0);
    chk("rst_wb_valid", {31'd0, a_wb_valid}, 0);
    chk("rst_busy", {30'd0, a_busy}, 0);
    chk("rst_dc_addr", {16'd0, a_dc_addr}, 0);
    chk("rst_wb_data", a_wb_data, 0);
    chk("rst_bad_tid", {31'd0, a_bad}, 0);
    chk("rst_spurious", {31'd0, a_spur}, 0);
    cyc();

    // 1: ALU op
    wb_ready = 1;
    wb_q.push_back('{1'b1, 1'b1, 5'd5, 32'h1234});
    set_op(0, 0, 32'h1234, 0, 1, 5'd5);
    a_tid = 1; a_valid = 1; cyc(); a_valid = 0;
    @(negedge clk);
    chk("t1_wb_valid", {31'd0, a_wb_valid}, 1);
    chk("t1_ready_low", {31'd0, a_ready}, 0);
    cyc();
    @(negedge clk);
    chk("t1_ready_back", {31'd0, a_ready}, 1);
    cyc();

    // 2: load, cache ready after 3 stalled cycles
    dc_q.push_back('{1'b0, 16'h8040, 32'h0});
    wb_q.push_back('{1'b1, 1'b1, 5'd7, 32'hDEADBEEF});
    dc_ready = 0;
    set_op(1, 0, 32'h0040, 0, 1, 5'd7);
    a_tid = 1; a_valid = 1; cyc(); a_valid = 0;
    repeat (3) begin
      @(negedge clk); chk("t2_busy_req", {30'd0, a_busy}, 2'b10); cyc();
    end
    dc_ready = 1;
    @(negedge clk); chk("t2_busy_acc", {30'd0, a_busy}, 2'b10);
    cyc(); dc_ready = 0;
    rsp_valid = 1; rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_busy_wait", {30'd0, a_busy}, 2'b10);
    chk("t2_no_wb_in_wait", {31'd0, a_wb_valid}, 0);
    cyc(); rsp_valid = 0;
    @(negedge clk);
    chk("t2_busy_wb", {30'd0, a_busy}, 2'b10);
    chk("t2_wb_valid", {31'd0, a_wb_valid}, 1);
    cyc();
    @(negedge clk);
    chk("t2_busy_idle", {30'd0, a_busy}, 0);
    chk("t2_ready", {31'd0, a_ready}, 1);
    cyc();

    // 3: store, 5 stalled cycles, no WB beat
    dc_q.push_back('{1'b1, 16'h7FFF, 32'hCAFEF00D});
    set_op(1, 1, 32'hFFFF, 32'hCAFEF00D, 0, 5'd0);
    a_tid = 0; a_valid = 1; cyc(); a_valid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_busy", {30'd0, a_busy}, 2'b01);
      chk("t3_ready_low", {31'd0, a_ready}, 0);
      cyc();
    end
    dc_ready = 1; cyc(); dc_ready = 0;
    @(negedge clk);
    chk("t3_ready_after_acc", {31'd0, a_ready}, 1);
    chk("t3_no_wb", {31'd0, a_wb_valid}, 0);
    repeat (2) cyc();

    // 5: spurious response in IDLE, then reset during WAIT
    rsp_valid = 1; rsp_data = 32'h99; cyc(); rsp_valid = 0;
    @(negedge clk);
    chk("t5_spur_pulse", {31'd0, a_spur}, 1);
    chk("t5_spur_no_wb", {31'd0, a_wb_valid}, 0);
    chk("t5_spur_idle", {31'd0, a_ready}, 1);
    cyc();
    @(negedge clk); chk("t5_spur_one_cycle", {31'd0, a_spur}, 0);
    cyc();
    dc_q.push_back('{1'b0, 16'h0010, 32'h0});
    set_op(1, 0, 32'h0010, 0, 1, 5'd3);
    a_tid = 0; a_valid = 1; dc_ready = 1; cyc(); a_valid = 0;
    cyc(); dc_ready = 0;
    @(negedge clk);
    chk("t5_busy_wait", {30'd0, a_busy}, 2'b01);
    chk("t5_wait_ready", {31'd0, a_ready}, 0);
    cyc();
    rst = 1; cyc(); rst = 0;
    @(negedge clk);
    chk("t5_rst_dc_valid", {31'd0, a_dc_valid}, 0);
    chk("t5_rst_wb_valid", {31'd0, a_wb_valid}, 0);
    chk("t5_rst_ready", {31'd0, a_ready}, 1);
    chk("t5_rst_busy", {30'd0, a_busy}, 0);
    chk("t5_rst_dc_addr", {16'd0, a_dc_addr}, 0);
    cyc();
    rsp_valid = 1; rsp_data = 32'h5; cyc(); rsp_valid = 0;
    @(negedge clk);
    chk("t5_late_spur", {31'd0, a_spur}, 1);
    chk("t5_late_no_wb", {31'd0, a_wb_valid}, 0);
    cyc();

    // 4: three threads, invalid thread ID dropped
    set_op(1, 0, 32'h0040, 0, 1, 5'd2);
    b_tid = 2'd3; b_valid = 1; cyc(); b_valid = 0;
    @(negedge clk);
    chk("t4_bad_tid", {31'd0, b_bad}, 1);
    chk("t4_no_dc", {31'd0, b_dc_valid}, 0);
    chk("t4_no_wb", {31'd0, b_wb_valid}, 0);
    chk("t4_ready", {31'd0, b_ready}, 1);
    cyc();
    @(negedge clk);
    chk("t4_bad_one_cycle", {31'd0, b_bad}, 0);
    chk("t4_still_no_dc", {31'd0, b_dc_valid}, 0);
    cyc();
    wb_ready = 1;
    set_op(0, 0, 32'h77, 0, 1, 5'd4);
    b_tid = 2'd2; b_valid = 1; cyc(); b_valid = 0;
    @(negedge clk);
    chk("t4_next_wb_valid", {31'd0, b_wb_valid}, 1);
    chk("t4_next_wb_tid", {30'd0, b_wb_tid}, 2);
    chk("t4_next_wb_data", b_wb_data, 32'h77);
    chk("t4_next_busy", {29'd0, b_busy}, 3'b100);
    cyc();
    @(negedge clk); chk("t4_next_ready", {31'd0, b_ready}, 1);
    cyc();

    // 6: untagged address, WB held under backpressure
    dc_ready = 0; wb_ready = 0;
    set_op(1, 0, 32'h0040, 0, 1, 5'd9);
    c_tid = 1; c_valid = 1; cyc(); c_valid = 0;
    @(negedge clk);
    chk("t6_dc_valid", {31'd0, c_dc_valid}, 1);
    chk("t6_dc_addr", {16'd0, c_dc_addr}, 32'h0040);
    cyc();
    dc_ready = 1; cyc(); dc_ready = 0;
    rsp_valid = 1; rsp_data = 32'h12345678; cyc(); rsp_valid = 0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_wb_valid", {31'd0, c_wb_valid}, 1);
      chk("t6_wb_data", c_wb_data, 32'h12345678);
      chk("t6_wb_ra", {27'd0, c_wb_ra}, 9);
      chk("t6_wb_tid", {31'd0, c_wb_tid}, 1);
      chk("t6_ready_low", {31'd0, c_ready}, 0);
      cyc();
    end
    wb_ready = 1; cyc(); wb_ready = 0;
    @(negedge clk);
    chk("t6_ready_back", {31'd0, c_ready}, 1);
    chk("t6_wb_done", {31'd0, c_wb_valid}, 0);

    chk("dc_queue_drained", dc_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
